alu_seq: RTL and testbench
==========================

# alu_seq

Sequential controller that drives the 4-bit `alu` port set (operands, `ALUOp`, `arit`) and consumes its outputs (`R`, `carry`, `zero`, `sign`). It accepts one command per start pulse and issues single-pass arithmetic: add, subtract and negate. It also runs an unsigned 4×4→8 shift-add multiply by iterating ADD passes through the ALU. It sits between the practice top level and an externally instanced `alu`.

## Interface
Parameters: none.

Clock and reset:
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.

Command side:
- `start` input, 1 bit: command request, sampled only in IDLE.
- `op` input, 2 bits: 00 ADD, 01 SUB (a−b), 10 MUL, 11 NEG (−a).
- `a_in`, `b_in` input, 4 bits each: operands, latched on acceptance.
- `busy` output, 1 bit: high in EXEC, MUL and DONE.
- `done` output, 1 bit: one-cycle pulse, high in DONE.
- `result` output, 8 bits: result; `{4'b0000, R}` for single ops, product for MUL.
- `flag_z`, `flag_c`, `flag_s` output, 1 bit each: registered flags (see Configuration).

ALU side:
- `alu_A`, `alu_B` output, 4 bits each: ALU operands.
- `alu_ALUOp` output, 2 bits: ALU operation code.
- `alu_arit` output, 1 bit: arithmetic select.
- `alu_R` input, 4 bits: ALU result.
- `alu_zero`, `alu_carry`, `alu_sign` input, 1 bit each: ALU flags.

## Operation
States:
- IDLE → EXEC when `start` is high and `op` ≠ MUL.
- IDLE → MUL when `start` is high and `op` = MUL.
- EXEC → DONE.
- MUL → MUL while `cnt` < 3; MUL → DONE when `cnt` = 3.
- DONE → IDLE.

Command acceptance:
- On acceptance, latch `a_in`/`b_in` into M/Q, clear P, C and `cnt`.
- `start` is ignored in every state other than IDLE; it is not queued.

ALU drive per state:
- IDLE and DONE: `alu_A`, `alu_B`, `alu_ALUOp` all 0; `alu_arit` = 0.
- EXEC, ADD: `alu_arit` = 1, `alu_ALUOp` = 00, `alu_A` = latched a, `alu_B` = latched b.
- EXEC, SUB: as ADD but `alu_ALUOp` = 01.
- EXEC, NEG: as ADD but `alu_ALUOp` = 10.
- MUL: `alu_arit` = 1, `alu_ALUOp` = 00, `alu_A` = P, `alu_B` = Q[0] ? M : 0.

Register updates:
- EXEC edge: `result` ← `{4'b0, alu_R}`.
- Each MUL edge: P ← `{alu_carry, alu_R[3:1]}`, Q ← `{alu_R[0], Q[3:1]}`, `cnt` + 1.
- Entering DONE from MUL: `result` ← `{P, Q}` as updated on that edge.

Arithmetic and result rules:
- All arithmetic is modulo 16 per pass; the carry of the final MUL pass is preserved inside P.
- `result` holds its value from DONE until the next accepted command updates it.

Reset:
- Any `rst_n` low, including mid-MUL, immediately forces IDLE and zeroes every register and output.
- No `done` pulse is produced for an aborted command.

## Timing
- Reset value of every output is 0.
- Start accepted at edge k:
  - Single op: EXEC in cycle k+1, `done` high in cycle k+2.
  - MUL: MUL in cycles k+1..k+4, `done` high in cycle k+5.
- `busy` rises in cycle k+1 and falls in the cycle after `done`. A new `start` is therefore accepted no earlier than edge k+3 (single op) or k+6 (MUL).
- ALU outputs are used combinationally within the same cycle; there is no pipelining inside `alu_seq`.

## Configuration
Macro `ALU_SEQ_FLAGS_EN`.

Defined:
- Flags are registered on the same edge as `result`.
- Single ops: `flag_z` = `alu_zero`, `flag_c` = `alu_carry`, `flag_s` = `alu_sign`.
- MUL: `flag_z` = (product == 0), `flag_c` = 0, `flag_s` = product[7].
- Flags hold until the next result update.

Undefined: the flag ports remain and are tied to 0; no flag registers are built.

## Structure
Package `alu_seq_pkg` holds:
- the state enum (IDLE, EXEC, MUL, DONE);
- command codes OP_ADD, OP_SUB, OP_MUL, OP_NEG;
- ALU codes ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_NEGA = 10, ALUOP_NEGB = 11.

`alu_seq` is a single module with no sub-module. The `alu` is instanced beside it by the integrating top.

## Test plan
- ADD a=7, b=9 → `result` 8'h00, `flag_z` 1, `flag_c` 1, `done` exactly 2 cycles after the accepting edge.
- SUB a=3, b=5 → `result` 8'h0E, `flag_c` 0, `flag_s` 1; NEG a=1 → `result` 8'h0F.
- MUL 15×15 → `result` 8'hE1, `done` 5 cycles after acceptance, `flag_s` 1, `flag_c` 0; MUL 0×9 → 8'h00 with `flag_z` 1.
- MUL 3×4 with `start` held high throughout `busy` → `result` 8'h0C, exactly one `done` pulse, a second command accepted only after return to IDLE.
- `rst_n` pulsed low during the second MUL cycle of 15×15 → `busy`, `done` and `result` go to 0 asynchronously, no `done`; a following ADD 1+1 → 8'h02.
- Build without `ALU_SEQ_FLAGS_EN`, rerun ADD 7+9 → `result` 8'h00, all flags 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and codes for the alu_seq controller: FSM states, command
// opcodes and the opcode set understood by the external 4-bit alu.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_NEGA = 2'b10;
    localparam logic [1:0] ALUOP_NEGB = 2'b11;

endpackage

// File: rtl/alu_seq.sv
// Sequencer around an external 4-bit alu: single-pass ADD/SUB/NEG and a
// 4x4->8 shift-add multiply. Optional flag registers under ALU_SEQ_FLAGS_EN.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_s,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [1:0] alu_ALUOp,
    output logic       alu_arit,
    input  logic [3:0] alu_R,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_sign
);

    state_t     state_r, next_s;
    logic [3:0] m_r, q_r, p_r;
    logic [1:0] cnt_r, op_r;
    logic [7:0] result_r;
    logic       busy_r, done_r;
    logic [3:0] p_nxt_s, q_nxt_s;
    logic [7:0] product_s;
    logic       mul_last_s;

    // Shift-add step: the pass carry lands in P's MSB, R's LSB shifts into Q.
    assign p_nxt_s    = {alu_carry, alu_R[3:1]};
    assign q_nxt_s    = {alu_R[0], q_r[3:1]};
    assign product_s  = {p_nxt_s, q_nxt_s};
    assign mul_last_s = (cnt_r == 2'd3);

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = (op == OP_MUL) ? MUL : EXEC;
                end else begin
                    next_s = IDLE;
                end
            end
            EXEC: next_s = DONE;
            MUL: begin
                if (mul_last_s) begin
                    next_s = DONE;
                end else begin
                    next_s = MUL;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // ALU drive is decoded from registered state so the alu result is
    // consumed in the same cycle without a pipeline stage.
    always_comb begin
        alu_A     = 4'd0;
        alu_B     = 4'd0;
        alu_ALUOp = ALUOP_ADD;
        alu_arit  = 1'b0;
        case (state_r)
            EXEC: begin
                alu_arit = 1'b1;
                alu_A    = m_r;
                alu_B    = q_r;
                case (op_r)
                    OP_SUB:  alu_ALUOp = ALUOP_SUB;
                    OP_NEG:  alu_ALUOp = ALUOP_NEGA;
                    default: alu_ALUOp = ALUOP_ADD;
                endcase
            end
            MUL: begin
                alu_arit  = 1'b1;
                alu_ALUOp = ALUOP_ADD;
                alu_A     = p_r;
                alu_B     = q_r[0] ? m_r : 4'd0;
            end
            default: begin
                alu_arit  = 1'b0;
                alu_ALUOp = ALUOP_ADD;
            end
        endcase
    end

    // State, operand/product registers and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            m_r      <= 4'd0;
            q_r      <= 4'd0;
            p_r      <= 4'd0;
            cnt_r    <= 2'd0;
            op_r     <= 2'd0;
            result_r <= 8'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != IDLE);
            done_r  <= (next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r   <= a_in;
                        q_r   <= b_in;
                        p_r   <= 4'd0;
                        cnt_r <= 2'd0;
                        op_r  <= op;
                    end
                end
                EXEC: result_r <= {4'b0000, alu_R};
                MUL: begin
                    p_r   <= p_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r + 2'd1;
                    if (mul_last_s) begin
                        result_r <= product_s;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_r, flag_c_r, flag_s_r;

    // Flags update on the same edges as result and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_s_r <= 1'b0;
        end else begin
            case (state_r)
                EXEC: begin
                    flag_z_r <= alu_zero;
                    flag_c_r <= alu_carry;
                    flag_s_r <= alu_sign;
                end
                MUL: begin
                    if (mul_last_s) begin
                        flag_z_r <= (product_s == 8'd0);
                        flag_c_r <= 1'b0;
                        flag_s_r <= product_s[7];
                    end
                end
                default: begin
                    flag_z_r <= flag_z_r;
                end
            endcase
        end
    end

    assign flag_z = flag_z_r;
    assign flag_c = flag_c_r;
    assign flag_s = flag_s_r;
`else
    logic unused_flags_s;
    assign unused_flags_s = alu_zero ^ alu_sign;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_s = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit alu beside it.
// Flag expectations follow ALU_SEQ_FLAGS_EN as seen by this compile.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk, rst_n, start;
    logic [1:0] op;
    logic [3:0] a_in, b_in;
    logic       busy, done, flag_z, flag_c, flag_s;
    logic [7:0] result;
    logic [3:0] alu_A, alu_B, alu_R;
    logic [1:0] alu_ALUOp;
    logic       alu_arit, alu_zero, alu_carry, alu_sign;
    logic [4:0] sum_s;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUOp(alu_ALUOp), .alu_arit(alu_arit),
        .alu_R(alu_R), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference alu: subtraction and negation in two's complement via inverse-plus-one
    always_comb begin
        sum_s = 5'd0;
        if (alu_arit) begin
            case (alu_ALUOp)
                2'b00:   sum_s = {1'b0, alu_A} + {1'b0, alu_B};
                2'b01:   sum_s = {1'b0, alu_A} + {1'b0, ~alu_B} + 5'd1;
                2'b10:   sum_s = {1'b0, ~alu_A} + 5'd1;
                default: sum_s = {1'b0, ~alu_B} + 5'd1;
            endcase
        end else begin
            sum_s = {1'b0, alu_A & alu_B};
        end
    end
    assign alu_R     = sum_s[3:0];
    assign alu_carry = sum_s[4];
    assign alu_zero  = (sum_s[3:0] == 4'd0);
    assign alu_sign  = sum_s[3];

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       s;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_flags(input string name, input logic z, input logic c, input logic s);
`ifdef ALU_SEQ_FLAGS_EN
        check({name, ".flags"}, {29'd0, flag_z, flag_c, flag_s}, {29'd0, z, c, s});
`else
        check({name, ".flags"}, {29'd0, flag_z, flag_c, flag_s}, {29'd0, 1'b0, 1'b0, 1'b0});
`endif
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int cyc;
        logic [1:0] exp_aluop;
        logic [3:0] exp_a, exp_b;
        exp_aluop = (v.op == OP_SUB) ? ALUOP_SUB : (v.op == OP_NEG) ? ALUOP_NEGA : ALUOP_ADD;
        exp_a = (v.op == OP_MUL) ? 4'd0 : v.a;
        exp_b = (v.op == OP_MUL) ? (v.b[0] ? v.a : 4'd0) : v.b;
        @(negedge clk);
        start = 1'b1; op = v.op; a_in = v.a; b_in = v.b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({name, ".busy"}, {31'd0, busy}, 32'd1);
        check({name, ".drive"}, {21'd0, alu_arit, alu_ALUOp, alu_A, alu_B},
              {21'd0, 1'b1, exp_aluop, exp_a, exp_b});
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, ".latency"}, cyc, v.lat);
        check({name, ".result"}, {24'd0, result}, {24'd0, v.res});
        check_flags(name, v.z, v.c, v.s);
        @(negedge clk);
        check({name, ".idle"}, {30'd0, busy, done}, 32'd0);
        check({name, ".hold"}, {24'd0, result}, {24'd0, v.res});
    endtask

    initial begin
        int ndone;
        int cyc;
        vecs[0] = '{OP_ADD, 4'd7,  4'd9,  8'h00, 1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{OP_SUB, 4'd3,  4'd5,  8'h0E, 1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{OP_NEG, 4'd1,  4'd0,  8'h0F, 1'b0, 1'b0, 1'b1, 2};
        vecs[3] = '{OP_SUB, 4'd5,  4'd5,  8'h00, 1'b1, 1'b1, 1'b0, 2};
        vecs[4] = '{OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 1'b1, 5};
        vecs[5] = '{OP_MUL, 4'd0,  4'd9,  8'h00, 1'b1, 1'b0, 1'b0, 5};
        vecs[6] = '{OP_MUL, 4'd12, 4'd11, 8'h84, 1'b0, 1'b0, 1'b1, 5};
        vecs[7] = '{OP_MUL, 4'd9,  4'd13, 8'h75, 1'b0, 1'b0, 1'b0, 5};

        rst_n = 1'b0; start = 1'b0; op = 2'd0; a_in = 4'd0; b_in = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset.status", {23'd0, busy, done, result}, 32'd0);
        check("reset.drive", {21'd0, alu_arit, alu_ALUOp, alu_A, alu_B}, 32'd0);
        check("reset.flags", {29'd0, flag_z, flag_c, flag_s}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // start held high through a MUL: one done, re-accept only from IDLE
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a_in = 4'd3; b_in = 4'd4;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c < 5) check($sformatf("held.busy%0d", c), {31'd0, busy}, 32'd1);
        end
        check("held.done_at5", {31'd0, done}, 32'd1);
        check("held.ndone", ndone, 1);
        check("held.result", {24'd0, result}, 32'h0000000C);
        @(negedge clk);
        check("held.idle_gap", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        check("held.reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("held.second_done", {31'd0, done}, 32'd1);
        check("held.second_result", {24'd0, result}, 32'h0000000C);
        @(negedge clk);

        // asynchronous reset during the second MUL cycle of 15x15
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a_in = 4'd15; b_in = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check("abort.pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort.status", {23'd0, busy, done, result}, 32'd0);
        check("abort.drive", {21'd0, alu_arit, alu_ALUOp, alu_A, alu_B}, 32'd0);
        check("abort.flags", {29'd0, flag_z, flag_c, flag_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort.no_done", ndone, 0);
        run_vec("after_abort", '{OP_ADD, 4'd1, 4'd1, 8'h02, 1'b0, 1'b0, 1'b0, 2});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
